// File: rtl/assoc_cache.sv
`timescale 1ns/1ps
// assoc_cache: set-associative write-back/write-allocate data cache with true-LRU
// replacement, whole-cache flush and saturating hit/miss counters; hits are zero-latency.
module assoc_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            data_address,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic                             MemWrite,
    input  logic                             MemRead,
    input  logic                             AddrMode,
    input  logic                             flush,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic                             stall,
    output logic                             flush_done,
    output logic                             mem_req,
    output logic                             WriteEnable,
    output logic [ADDR_WIDTH-1:0]            memory_address,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] mem_writedata,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_readdata,
    input  logic                             mem_ready,
    output logic [31:0]                      hit_count,
    output logic [31:0]                      miss_count
);
    localparam int LW     = LINE_WORDS * DATA_WIDTH;
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WB, S_REFILL, S_FSCAN, S_FWB} state_t;

    state_t                r_state;
    logic                  r_valid [SETS][WAYS];
    logic                  r_dirty [SETS][WAYS];
    logic [WAY_W-1:0]      r_age   [SETS][WAYS];
    logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
    logic [LW-1:0]         r_data  [SETS][WAYS];
    logic [WAY_W-1:0]      r_vway, r_fway;
    logic [TAG_W-1:0]      r_rtag;
    logic [IDX_W-1:0]      r_ridx, r_fset;
    logic                  r_flush_hold, r_flush_done, r_mem_req, r_we;
    logic [ADDR_WIDTH-1:0] r_maddr;
    logic [LW-1:0]         r_mwdata;
    logic [31:0]           r_hits, r_misses;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [WSEL_W-1:0]     w_wsel;
    logic [1:0]            w_lane;
    logic                  w_hit, w_found, w_access, w_idle, w_hit_acc, w_miss, w_flush_go;
    logic                  w_flast;
    logic [WAY_W-1:0]      w_hit_way, w_victim;
    logic [LW-1:0]         w_line;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_idx  = data_address[OFF_W +: IDX_W];
    assign w_tag  = data_address[ADDR_WIDTH-1 -: TAG_W];
    assign w_wsel = (LINE_WORDS > 1) ? data_address[2 +: WSEL_W] : '0;
    assign w_lane = data_address[1:0];

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_found   = 1'b0;
        w_victim  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
        // Prefer the lowest empty way; otherwise the way whose age is the oldest.
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && !r_valid[w_idx][w]) begin
                w_found  = 1'b1;
                w_victim = WAY_W'(w);
            end
        end
        if (!w_found) begin
            for (int w = 0; w < WAYS; w++)
                if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(w);
        end
    end

    assign w_access   = MemRead | MemWrite;
    assign w_idle     = (r_state == S_IDLE);
    assign w_hit_acc  = w_idle & w_access & w_hit;
    assign w_miss     = w_idle & w_access & ~w_hit;
    assign w_flush_go = w_idle & ~w_access & flush & ~r_flush_hold;
    assign w_flast    = (r_fset == IDX_W'(SETS - 1)) && (r_fway == WAY_W'(WAYS - 1));
    assign w_line     = r_data[w_idx][w_hit_way];
    assign w_word     = w_line[{w_wsel, 5'd0} +: DATA_WIDTH];

    assign stall          = ~w_idle | w_miss | w_flush_go;
    assign read_data      = (MemRead & w_hit_acc) ?
                            (AddrMode ? {24'd0, w_word[{w_lane, 3'd0} +: 8]} : w_word) : '0;
    assign flush_done     = r_flush_done;
    assign mem_req        = r_mem_req;
    assign WriteEnable    = r_we;
    assign memory_address = r_maddr;
    assign mem_writedata  = r_mwdata;
    assign hit_count      = r_hits;
    assign miss_count     = r_misses;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_vway       <= '0;
            r_fway       <= '0;
            r_rtag       <= '0;
            r_ridx       <= '0;
            r_fset       <= '0;
            r_flush_hold <= 1'b0;
            r_flush_done <= 1'b0;
            r_mem_req    <= 1'b0;
            r_we         <= 1'b0;
            r_maddr      <= '0;
            r_mwdata     <= '0;
            r_hits       <= '0;
            r_misses     <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_age[s][w]   <= WAY_W'(w);
                end
        end else begin
            r_flush_done <= 1'b0;
            r_flush_hold <= flush & (r_flush_hold | w_flush_go);
            case (r_state)
                S_IDLE: begin
                    if (w_hit_acc) begin
                        if (r_hits != 32'hFFFF_FFFF) r_hits <= r_hits + 32'd1;
                        if (MemWrite) r_dirty[w_idx][w_hit_way] <= 1'b1;
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == w_hit_way)
                                r_age[w_idx][w] <= '0;
                            else if (r_age[w_idx][w] < r_age[w_idx][w_hit_way])
                                r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                        end
                    end else if (w_miss) begin
                        if (r_misses != 32'hFFFF_FFFF) r_misses <= r_misses + 32'd1;
                        r_vway    <= w_victim;
                        r_rtag    <= w_tag;
                        r_ridx    <= w_idx;
                        r_mem_req <= 1'b1;
                        if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                            r_state  <= S_WB;
                            r_we     <= 1'b1;
                            r_maddr  <= {r_tag[w_idx][w_victim], w_idx, {OFF_W{1'b0}}};
                            r_mwdata <= r_data[w_idx][w_victim];
                        end else begin
                            r_state <= S_REFILL;
                            r_we    <= 1'b0;
                            r_maddr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                        end
                    end else if (w_flush_go) begin
                        r_state <= S_FSCAN;
                        r_fset  <= '0;
                        r_fway  <= '0;
                    end
                end
                S_WB: if (mem_ready) begin
                    r_state <= S_REFILL;
                    r_we    <= 1'b0;
                    r_maddr <= {r_rtag, r_ridx, {OFF_W{1'b0}}};
                end
                S_REFILL: if (mem_ready) begin
                    r_state                <= S_IDLE;
                    r_mem_req              <= 1'b0;
                    r_valid[r_ridx][r_vway] <= 1'b1;
                    r_dirty[r_ridx][r_vway] <= 1'b0;
                end
                S_FSCAN: begin
                    if (r_valid[r_fset][r_fway] && r_dirty[r_fset][r_fway]) begin
                        r_state   <= S_FWB;
                        r_mem_req <= 1'b1;
                        r_we      <= 1'b1;
                        r_maddr   <= {r_tag[r_fset][r_fway], r_fset, {OFF_W{1'b0}}};
                        r_mwdata  <= r_data[r_fset][r_fway];
                    end else if (w_flast) begin
                        r_state      <= S_IDLE;
                        r_flush_done <= 1'b1;
                        for (int s = 0; s < SETS; s++)
                            for (int w = 0; w < WAYS; w++) begin
                                r_valid[s][w] <= 1'b0;
                                r_dirty[s][w] <= 1'b0;
                                r_age[s][w]   <= WAY_W'(w);
                            end
                    end else if (r_fway == WAY_W'(WAYS - 1)) begin
                        r_fway <= '0;
                        r_fset <= r_fset + 1'b1;
                    end else begin
                        r_fway <= r_fway + 1'b1;
                    end
                end
                // The entry is cleaned and re-scanned, so the scan pointer advances from one place.
                S_FWB: if (mem_ready) begin
                    r_state                 <= S_FSCAN;
                    r_mem_req               <= 1'b0;
                    r_we                    <= 1'b0;
                    r_dirty[r_fset][r_fway] <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_hit_acc && MemWrite) begin
            if (AddrMode)
                r_data[w_idx][w_hit_way][{w_wsel, w_lane, 3'd0} +: 8] <= write_data[7:0];
            else
                r_data[w_idx][w_hit_way][{w_wsel, 5'd0} +: DATA_WIDTH] <= write_data;
        end
        if (r_state == S_REFILL && mem_ready) begin
            r_data[r_ridx][r_vway] <= mem_readdata;
            r_tag[r_ridx][r_vway]  <= r_rtag;
        end
    end
endmodule
